// File: rtl/atm_pkg.sv
// Shared codes for the ATM keypad verifier and controller:
// status pulses, input styles, key codes, menu codes and a BCD compare helper.
package atm_pkg;

    localparam int MAX_DIGITS_DEF = 4;

    localparam logic [3:0] ST_IDLE           = 4'h0;
    localparam logic [3:0] ST_ACC_FOUND      = 4'h1;
    localparam logic [3:0] ST_ACC_NOT_FOUND  = 4'h2;
    localparam logic [3:0] ST_PIN_CORRECT    = 4'h3;
    localparam logic [3:0] ST_PIN_INCORRECT  = 4'h4;
    localparam logic [3:0] ST_AMT_VALID      = 4'h5;
    localparam logic [3:0] ST_AMT_INVALID    = 4'h6;
    localparam logic [3:0] ST_EXIT           = 4'h7;
    localparam logic [3:0] ST_INPUT_COMPLETE = 4'h8;

    localparam logic [3:0] IS_SINGLE_KEY      = 4'd1;
    localparam logic [3:0] IS_ACC_NUMBER      = 4'd2;
    localparam logic [3:0] IS_PIN_NUMBER      = 4'd3;
    localparam logic [3:0] IS_MENU_SELECTION  = 4'd4;
    localparam logic [3:0] IS_CURRENCY_TYPE   = 4'd5;
    localparam logic [3:0] IS_CURRENCY_AMOUNT = 4'd6;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
    localparam logic [3:0] KEY_ENTER     = 4'hA;
    localparam logic [3:0] KEY_CLEAR     = 4'hB;
    localparam logic [3:0] KEY_CANCEL    = 4'hC;

    localparam logic [1:0] MENU_BALANCE  = 2'd0;
    localparam logic [1:0] MENU_CONVERT  = 2'd1;
    localparam logic [1:0] MENU_WITHDRAW = 2'd2;
    localparam logic [1:0] MENU_TRANSFER = 2'd3;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_LOOKUP  = 2'd1,
        S_REPORT  = 2'd2
    } verify_state_e;

    // a <= b over four BCD digits, most significant digit decides first
    function automatic logic bcd_le(input logic [15:0] a, input logic [15:0] b);
        logic result;
        logic decided;
        result  = 1'b1;
        decided = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
                result  = (a[4*i +: 4] < b[4*i +: 4]);
                decided = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/atm_account_rom.sv
// Account table: combinational index lookup returning the BCD account number and PIN.
import atm_pkg::*;

module atm_account_rom #(
    parameter int NUM_ACCOUNTS = 4
) (
    input  logic [3:0]  idx_i,
    output logic [15:0] acct_num_o,
    output logic [15:0] pin_o
);

    localparam logic [15:0] ACCT_0 = 16'h4321;
    localparam logic [15:0] PIN_0  = 16'h1111;
    localparam logic [15:0] ACCT_1 = 16'h5678;
    localparam logic [15:0] PIN_1  = 16'h2468;
    localparam logic [15:0] ACCT_2 = 16'h1234;
    localparam logic [15:0] PIN_2  = 16'h9876;
    localparam logic [15:0] ACCT_3 = 16'h1234;
    localparam logic [15:0] PIN_3  = 16'h5555;

    // Unpopulated slots read as non-BCD so they can never match a keyed entry
    always_comb begin
        acct_num_o = 16'hFFFF;
        pin_o      = 16'hFFFF;
        if (32'(idx_i) < NUM_ACCOUNTS) begin
            unique case (idx_i)
                4'd0: begin acct_num_o = ACCT_0; pin_o = PIN_0; end
                4'd1: begin acct_num_o = ACCT_1; pin_o = PIN_1; end
                4'd2: begin acct_num_o = ACCT_2; pin_o = PIN_2; end
                4'd3: begin acct_num_o = ACCT_3; pin_o = PIN_3; end
                default: begin
                    acct_num_o = {12'h900, idx_i};
                    pin_o      = {12'h000, idx_i};
                end
            endcase
        end
    end

endmodule

// File: rtl/atm_keypad_verifier.sv
// Keypad entry collector and verifier: assembles BCD entries per input style
// and answers the controller with registered one-cycle status pulses.
import atm_pkg::*;

module atm_keypad_verifier #(
    parameter int NUM_ACCOUNTS   = 4,
    parameter int MAX_DIGITS     = MAX_DIGITS_DEF,
    parameter int NUM_CURRENCIES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic [3:0]  input_style,
    input  logic [15:0] avail_balance,
    output logic [3:0]  status_code,
    output logic        status_valid,
    output logic [1:0]  menu_sel,
    output logic [1:0]  currency_sel,
    output logic [15:0] amount,
    output logic [3:0]  acct_index,
    output logic [2:0]  digit_count,
    output logic        busy
);

    localparam int         BUF_W     = 4 * MAX_DIGITS;
    localparam logic [2:0] FULL_CNT  = 3'(MAX_DIGITS);
    localparam logic [3:0] LAST_SCAN = 4'(NUM_ACCOUNTS - 1);

    verify_state_e state_q, state_d;
    logic [3:0]       style_q, style_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [3:0]       status_q, status_d;
    logic [1:0]       menu_q, menu_d;
    logic [1:0]       cur_q, cur_d;
    logic [15:0]      amount_q, amount_d;
    logic [3:0]       acct_q, acct_d;
    logic [3:0]       scan_q, scan_d;
    logic             found_q, found_d;
    logic [3:0]       fidx_q, fidx_d;

    logic             style_chg;
    logic             style_ok;
    logic [BUF_W-1:0] base_buf;
    logic [2:0]       base_cnt;
    logic [15:0]      base16;
    logic [15:0]      buf16;
    logic [3:0]       rom_idx;
    logic [15:0]      rom_acct;
    logic [15:0]      rom_pin;
    logic [3:0]       pulse;
    logic             match;

    // A style change discards any partial entry before the key of that cycle is applied
    assign style_chg = (input_style != style_q);
    assign style_ok  = (input_style >= IS_SINGLE_KEY) && (input_style <= IS_CURRENCY_AMOUNT);
    assign base_buf  = style_chg ? '0 : buf_q;
    assign base_cnt  = style_chg ? 3'd0 : cnt_q;

    generate
        if (BUF_W >= 16) begin : g_wide
            assign base16 = base_buf[15:0];
            assign buf16  = buf_q[15:0];
        end else begin : g_narrow
            assign base16 = {{(16-BUF_W){1'b0}}, base_buf};
            assign buf16  = {{(16-BUF_W){1'b0}}, buf_q};
        end
    endgenerate

    assign rom_idx = (state_q == S_LOOKUP) ? scan_q : acct_q;
    assign match   = (rom_acct == buf16);

    atm_account_rom #(
        .NUM_ACCOUNTS (NUM_ACCOUNTS)
    ) u_rom (
        .idx_i      (rom_idx),
        .acct_num_o (rom_acct),
        .pin_o      (rom_pin)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_COLLECT;
            style_q  <= '0;
            buf_q    <= '0;
            cnt_q    <= '0;
            status_q <= '0;
            menu_q   <= '0;
            cur_q    <= '0;
            amount_q <= '0;
            acct_q   <= '0;
            scan_q   <= '0;
            found_q  <= 1'b0;
            fidx_q   <= '0;
        end else begin
            state_q  <= state_d;
            style_q  <= style_d;
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            menu_q   <= menu_d;
            cur_q    <= cur_d;
            amount_q <= amount_d;
            acct_q   <= acct_d;
            scan_q   <= scan_d;
            found_q  <= found_d;
            fidx_q   <= fidx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        style_d  = style_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        status_d = ST_IDLE;
        menu_d   = menu_q;
        cur_d    = cur_q;
        amount_d = amount_q;
        acct_d   = acct_q;
        scan_d   = scan_q;
        found_d  = found_q;
        fidx_d   = fidx_q;
        pulse    = ST_IDLE;

        unique case (state_q)
            S_COLLECT: begin
                style_d = input_style;
                buf_d   = base_buf;
                cnt_d   = base_cnt;
                if (key_valid && style_ok) begin
                    if (key_code == KEY_CANCEL) begin
                        pulse = ST_EXIT;
                    end else if (input_style == IS_SINGLE_KEY) begin
                        if (key_code <= KEY_CLEAR) pulse = ST_INPUT_COMPLETE;
                    end else if (input_style == IS_MENU_SELECTION) begin
                        if (key_code <= 4'd3) begin
                            menu_d = key_code[1:0];
                            pulse  = ST_INPUT_COMPLETE;
                        end
                    end else if (input_style == IS_CURRENCY_TYPE) begin
                        if (32'(key_code) < NUM_CURRENCIES) begin
                            cur_d = key_code[1:0];
                            pulse = ST_INPUT_COMPLETE;
                        end
                    end else if (key_code <= KEY_DIGIT_MAX) begin
                        if (base_cnt < FULL_CNT) begin
                            buf_d = {base_buf[BUF_W-5:0], key_code};
                            cnt_d = base_cnt + 3'd1;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        buf_d = '0;
                        cnt_d = 3'd0;
                    end else if (key_code == KEY_ENTER) begin
                        if (input_style == IS_ACC_NUMBER) begin
                            if (base_cnt != FULL_CNT) begin
                                pulse = ST_ACC_NOT_FOUND;
                            end else begin
                                state_d = S_LOOKUP;
                                scan_d  = '0;
                                found_d = 1'b0;
                                fidx_d  = '0;
                            end
                        end else if (input_style == IS_PIN_NUMBER) begin
                            pulse = ((base_cnt == FULL_CNT) && (base16 == rom_pin))
                                    ? ST_PIN_CORRECT : ST_PIN_INCORRECT;
                        end else begin
                            if ((base16 != 16'h0) && bcd_le(base16, avail_balance)) begin
                                pulse    = ST_AMT_VALID;
                                amount_d = base16;
                            end else begin
                                pulse = ST_AMT_INVALID;
                            end
                        end
                    end
                end
                if (pulse != ST_IDLE) begin
                    status_d = pulse;
                    buf_d    = '0;
                    cnt_d    = 3'd0;
                    state_d  = S_REPORT;
                end
            end

            // Full-length scan; the first hit is remembered, later hits ignored
            S_LOOKUP: begin
                if (match && !found_q) begin
                    found_d = 1'b1;
                    fidx_d  = scan_q;
                end
                if (scan_q == LAST_SCAN) begin
                    if (found_q || match) begin
                        status_d = ST_ACC_FOUND;
                        acct_d   = found_q ? fidx_q : scan_q;
                    end else begin
                        status_d = ST_ACC_NOT_FOUND;
                    end
                    buf_d   = '0;
                    cnt_d   = 3'd0;
                    state_d = S_REPORT;
                end else begin
                    scan_d = scan_q + 4'd1;
                end
            end

            S_REPORT: state_d = S_COLLECT;

            default: state_d = S_COLLECT;
        endcase
    end

    assign status_code  = status_q;
    assign status_valid = (status_q != ST_IDLE);
    assign menu_sel     = menu_q;
    assign currency_sel = cur_q;
    assign amount       = amount_q;
    assign acct_index   = acct_q;
    assign digit_count  = cnt_q;
    assign busy         = (state_q == S_LOOKUP);

endmodule

// File: tb/tb_atm_keypad_verifier.sv
// Self-checking bench: directed scenarios plus random key sequences against a
// decimal-arithmetic model of the keypad entry rules.
module tb_atm_keypad_verifier;

    localparam int N_ACC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [3:0]  input_style;
    logic [15:0] avail_balance;
    logic [3:0]  status_code;
    logic        status_valid;
    logic [1:0]  menu_sel;
    logic [1:0]  currency_sel;
    logic [15:0] amount;
    logic [3:0]  acct_index;
    logic [2:0]  digit_count;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state, entry held as a plain decimal number
    int m_val, m_cnt, m_acct, m_menu, m_cur, m_style, m_bal;
    logic [15:0] m_amount;
    int accts [N_ACC] = '{4321, 5678, 1234, 1234};
    int pins  [N_ACC] = '{1111, 2468, 9876, 5555};

    atm_keypad_verifier dut (
        .clk           (clk),
        .rst           (rst),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .input_style   (input_style),
        .avail_balance (avail_balance),
        .status_code   (status_code),
        .status_valid  (status_valid),
        .menu_sel      (menu_sel),
        .currency_sel  (currency_sel),
        .amount        (amount),
        .acct_index    (acct_index),
        .digit_count   (digit_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int pow10(input int e);
        int p;
        p = 1;
        for (int i = 0; i < e; i++) p = p * 10;
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] exp_st, input logic exp_busy);
        check({tag, ".status"},   32'(status_code),  32'(exp_st));
        check({tag, ".valid"},    32'(status_valid), 32'(exp_st != 4'h0));
        check({tag, ".busy"},     32'(busy),         32'(exp_busy));
        check({tag, ".count"},    32'(digit_count),  32'(m_cnt));
        check({tag, ".menu"},     32'(menu_sel),     32'(m_menu));
        check({tag, ".currency"}, 32'(currency_sel), 32'(m_cur));
        check({tag, ".acct"},     32'(acct_index),   32'(m_acct));
        check({tag, ".amount"},   32'(amount),       32'(m_amount));
    endtask

    task automatic model_reset();
        m_val = 0; m_cnt = 0; m_acct = 0; m_menu = 0; m_cur = 0; m_amount = '0;
    endtask

    task automatic set_style(input int s);
        if (s != m_style) begin
            m_val = 0;
            m_cnt = 0;
        end
        m_style = s;
        input_style = 4'(s);
    endtask

    task automatic set_balance(input int b);
        m_bal = b;
        avail_balance = to_bcd(b);
    endtask

    // Apply one key at a negedge and check the DUT response on following negedges
    task automatic press(input logic [3:0] k);
        logic [3:0] exp;
        bit lookup;
        bit hit;
        exp = 4'h0;
        lookup = 0;
        if (m_style >= 1 && m_style <= 6) begin
            if (k == 4'hC) exp = 4'h7;
            else if (m_style == 1) begin
                if (k <= 4'hB) exp = 4'h8;
            end else if (m_style == 4) begin
                if (k <= 4'd3) begin exp = 4'h8; m_menu = int'(k); end
            end else if (m_style == 5) begin
                if (k < 4'd3) begin exp = 4'h8; m_cur = int'(k); end
            end else if (k <= 4'd9) begin
                if (m_cnt < 4) begin m_val = m_val * 10 + int'(k); m_cnt++; end
            end else if (k == 4'hB) begin
                m_val = 0; m_cnt = 0;
            end else if (k == 4'hA) begin
                if (m_style == 2) begin
                    if (m_cnt < 4) exp = 4'h2;
                    else begin
                        lookup = 1;
                        exp = 4'h2;
                        hit = 0;
                        for (int i = 0; i < N_ACC; i++)
                            if (!hit && accts[i] == m_val) begin hit = 1; m_acct = i; exp = 4'h1; end
                    end
                end else if (m_style == 3) begin
                    exp = (m_cnt == 4 && m_val == pins[m_acct]) ? 4'h3 : 4'h4;
                end else begin
                    if (m_val != 0 && m_val <= m_bal) begin exp = 4'h5; m_amount = to_bcd(m_val); end
                    else exp = 4'h6;
                end
            end
        end
        if (exp != 4'h0 || lookup) begin m_val = 0; m_cnt = 0; end

        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
        if (lookup) begin
            for (int i = 0; i < N_ACC; i++) begin
                check("lookup.busy", 32'(busy), 32'd1);
                check("lookup.quiet", 32'(status_code), 32'd0);
                @(negedge clk);
            end
        end
        check_outs("key", exp, 1'b0);
        $display("style=%0d key=%h status=%h expect=%h count=%0d acct=%0d menu=%0d cur=%0d amount=%h",
                 m_style, k, status_code, exp, digit_count, acct_index, menu_sel, currency_sel, amount);
        if (exp != 4'h0) begin
            @(negedge clk);
            check("pulse_end", 32'(status_code), 32'd0);
        end
    endtask

    task automatic press_num(input int v, input int n);
        for (int i = 0; i < n; i++) press(4'((v / pow10(n - 1 - i)) % 10));
    endtask

    int s, tgt, n;

    initial begin
        rst = 1'b1;
        key_valid = 1'b0;
        key_code = 4'h0;
        input_style = 4'h0;
        m_style = 0;
        set_balance(0);
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_outs("reset", 4'h0, 1'b0);

        // Account lookup: lowest matching index among duplicates
        set_style(2);
        press_num(1234, 4);
        press(4'hA);
        press_num(99, 2);
        press(4'hA);

        // PIN against account 2
        set_style(3);
        press_num(9876, 4);
        press(4'hA);
        press_num(98765, 5);
        press(4'hA);
        press_num(1111, 4);
        press(4'hA);

        // Amount against balance 500
        set_style(6);
        set_balance(500);
        press_num(500, 3);
        press(4'hA);
        press_num(501, 3);
        press(4'hA);
        press(4'hA);

        // Menu selection
        set_style(4);
        press(4'd7);
        press(4'd2);
        press(4'hC);

        // Reset in the middle of a lookup
        set_style(2);
        press_num(5678, 4);
        key_valid = 1'b1;
        key_code = 4'hA;
        @(negedge clk);
        key_valid = 1'b0;
        check("midrst.busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            check_outs("midrst", 4'h0, 1'b0);
            @(negedge clk);
        end
        press(4'd5);
        press(4'hB);

        // Random sequences across all styles
        for (int it = 0; it < 40; it++) begin
            s = int'($urandom_range(1, 6));
            set_style(s);
            if (s == 2 || s == 3 || s == 6) begin
                n = int'($urandom_range(0, 5));
                if (s == 2)
                    tgt = ($urandom_range(0, 1) == 1) ? accts[$urandom_range(0, N_ACC - 1)]
                                                      : int'($urandom_range(0, 9999));
                else if (s == 3)
                    tgt = ($urandom_range(0, 1) == 1) ? pins[m_acct] : int'($urandom_range(0, 9999));
                else begin
                    set_balance(int'($urandom_range(0, 9999)));
                    tgt = ($urandom_range(0, 2) == 0) ? m_bal : int'($urandom_range(0, 9999));
                end
                if (n >= 4 && $urandom_range(0, 1) == 1) n = 4;
                press_num(tgt, n);
                press(($urandom_range(0, 7) == 0) ? 4'hC : 4'hA);
            end else begin
                press(4'($urandom_range(0, 12)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/atm_keypad_verifier.md
Name: atm_keypad_verifier

Overview:
- Producer side of the ATM controller's status_code / input_style handshake. Collects keypad keys, assembles account-number, PIN, menu, currency and amount entries according to the controller's current input_style, and verifies them.
- Verification uses a small account ROM and an externally supplied balance.
- Emits one-cycle status_code pulses that drive the controller's state transitions.

Parameters:
- NUM_ACCOUNTS, 4, number of ROM account entries (1..16); also the fixed account-lookup scan length in cycles.
- MAX_DIGITS, 4, maximum BCD digits per entry; fixes the entry buffer at 4*MAX_DIGITS bits.
- NUM_CURRENCIES, 3, valid currency codes are 0..NUM_CURRENCIES-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- key_valid  in  1  one-cycle strobe; key_code is valid when high
- key_code  in  4  0-9 digit, 4'hA ENTER, 4'hB CLEAR, 4'hC CANCEL; 4'hD-F ignored
- input_style  in  4  controller input style (SINGLE_KEY=1 … CURRENCY_AMOUNT=6)
- avail_balance  in  16  BCD balance of the selected account/currency, from the ledger
- status_code  out  4  one-cycle code pulse; 4'h0 when idle
- status_valid  out  1  high exactly while status_code != 0
- menu_sel  out  2  latched menu choice (0 BALANCE, 1 CONVERT, 2 WITHDRAW, 3 TRANSFER)
- currency_sel  out  2  latched currency code
- amount  out  16  latched BCD amount (valid when AMT_VALID is pulsed)
- acct_index  out  4  latched index of the account found
- digit_count  out  3  digits currently buffered, for display echo
- busy  out  1  high during account lookup

Behaviour:
- Reset state: all outputs 0, buffer cleared, FSM in S_COLLECT. A reset mid-lookup aborts the lookup with no status pulse.
- FSM states:
  - S_COLLECT: accept keys.
  - S_LOOKUP: scan the ROM.
  - S_REPORT: drive the status pulse for one cycle, then return to S_COLLECT.
- Digit key in S_COLLECT:
  - Shift the BCD digit into the buffer LSB end and increment digit_count.
  - Once digit_count == MAX_DIGITS, further digits are dropped silently.
- CLEAR: zero the buffer and digit_count; no status.
- CANCEL in any style: EXIT (4'h7) pulse on the next cycle; buffer cleared.
- ENTER handling by input_style (every status pulse appears at T+1 after the key cycle T unless stated otherwise):
  - SINGLE_KEY: any key other than CANCEL, ENTER included, gives INPUT_COMPLETE (4'h8).
  - ACC_NUMBER:
    - ENTER with digit_count < MAX_DIGITS gives ACC_NOT_FOUND (4'h2) at T+1.
    - Otherwise enter S_LOOKUP, busy=1, and compare one ROM entry per cycle across all NUM_ACCOUNTS entries. The scan length is fixed and does not stop at the first match.
    - The pulse comes at T+NUM_ACCOUNTS+1: ACC_FOUND (4'h1) with acct_index latched to the lowest matching index, else ACC_NOT_FOUND.
  - PIN_NUMBER:
    - Compare the full buffer with the PIN of the latched acct_index.
    - Result is PIN_CORRECT (4'h3) or PIN_INCORRECT (4'h4).
    - A short entry is always PIN_INCORRECT.
  - MENU_SELECTION:
    - Digits 0-3 take effect on the key itself, without ENTER: latch menu_sel and pulse INPUT_COMPLETE.
    - Other digits are ignored.
  - CURRENCY_TYPE:
    - A digit < NUM_CURRENCIES latches currency_sel and pulses INPUT_COMPLETE on the key.
    - Other digits are ignored.
  - CURRENCY_AMOUNT, on ENTER:
    - Buffer nonzero and buffer <= avail_balance (BCD compare, equal-width, MSD first): AMT_VALID (4'h5) and amount latched.
    - Otherwise AMT_INVALID (4'h6).
    - Empty entry gives AMT_INVALID.
  - Any other input_style value: keys are ignored.
- After any status pulse, the buffer and digit_count are cleared.
- A change of input_style while in S_COLLECT clears the buffer. While in S_LOOKUP it is ignored until S_REPORT.
- key_valid during S_LOOKUP or S_REPORT is dropped. CANCEL is not honoured during a lookup.
- A CANCEL coincident with ENTER cannot occur, since there is a single key per strobe.
- status_code is registered; no combinational path from key inputs to outputs.

Decomposition:
- Shared package atm_pkg holds:
  - status codes
  - input-style codes
  - key codes
  - menu codes
  - MAX_DIGITS default
- The controller adopts the same package.
- Sub-module atm_account_rom: combinational index-in, {acct_num, pin} out, NUM_ACCOUNTS entries of 16-bit BCD each, contents defined as localparams.

Test Plan:
- Reset, then style=ACC_NUMBER, keys 1,2,3,4,ENTER, ROM[2]=1234 -> busy for 4 cycles, ACC_FOUND pulse at T+5, acct_index=2.
- style=ACC_NUMBER, keys 9,9,ENTER -> ACC_NOT_FOUND at T+1, digit_count returns to 0.
- style=PIN_NUMBER, acct_index=2, correct PIN -> PIN_CORRECT; 5 digits with first 4 correct -> fifth dropped, PIN_CORRECT; wrong PIN -> PIN_INCORRECT.
- style=CURRENCY_AMOUNT, avail_balance=16'h0500: keys 5,0,0,ENTER -> AMT_VALID, amount=16'h0500; keys 5,0,1,ENTER -> AMT_INVALID; ENTER alone -> AMT_INVALID.
- style=MENU_SELECTION: key 7 -> no pulse; key 2 -> INPUT_COMPLETE, menu_sel=2; key CANCEL -> EXIT.
- Assert rst during S_LOOKUP -> no status pulse, all outputs 0, a new entry is accepted on the next cycle.
